// File: rtl/match_round_controller.sv
// Match sequencer: intro countdown, timed fight with KO / time-out judging,
// result display, best-of-N match tracking and hold-to-restart.
// Every counter advances only on the 20 Hz game-tick strobe.

// Per-player round-win counter; saturates at WIN_ROUNDS.
module mrc_win_lane #(
  parameter int WIN_ROUNDS = 2,
  parameter int WW         = $clog2(WIN_ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          award,
  output logic [WW-1:0] wins,
  output logic          match_pt
);
  localparam logic [WW-1:0] WIN_LIM = WW'(WIN_ROUNDS);
  localparam logic [WW-1:0] PT_LIM  = WW'(WIN_ROUNDS - 1);

  // next round win for this player takes the match
  assign match_pt = (wins >= PT_LIM);

  // count awarded rounds; cleared on reset or on a full restart
  always_ff @(posedge clk) begin
    if (reset || clr)                  wins <= '0;
    else if (award && wins != WIN_LIM) wins <= wins + WW'(1);
  end
endmodule

module match_round_controller #(
  parameter int NUM_PLAYERS  = 2,
  parameter int HP_W         = 9,
  parameter int WIN_ROUNDS   = 2,
  parameter int ROUND_TICKS  = 1200,
  parameter int INTRO_TICKS  = 40,
  parameter int RESULT_TICKS = 60,
  parameter int HOLD_TICKS   = 40
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          tick,
  input  logic [NUM_PLAYERS*HP_W-1:0]                   health_flat,
  input  logic                                          restart_btn,
  input  logic                                          force_restart,
  output logic [1:0]                                    round_state,
  output logic                                          round_reset,
  output logic                                          freeze_inputs,
  output logic [$clog2(ROUND_TICKS+1)-1:0]              time_left,
  output logic [NUM_PLAYERS-1:0]                        round_winner,
  output logic                                          round_draw,
  output logic [NUM_PLAYERS-1:0]                        match_winner,
  output logic [NUM_PLAYERS*$clog2(WIN_ROUNDS+1)-1:0]   wins_flat
);
  localparam int TL_W   = $clog2(ROUND_TICKS + 1);
  localparam int WW     = $clog2(WIN_ROUNDS + 1);
  localparam int PH_MAX = (INTRO_TICKS > RESULT_TICKS) ? INTRO_TICKS : RESULT_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int HD_W   = $clog2(HOLD_TICKS + 1);

  localparam logic [TL_W-1:0] TL_INIT    = TL_W'(ROUND_TICKS);
  localparam logic [TL_W-1:0] TL_ONE     = TL_W'(1);
  localparam logic [PH_W-1:0] INTRO_LIM  = PH_W'(INTRO_TICKS);
  localparam logic [PH_W-1:0] RESULT_LIM = PH_W'(RESULT_TICKS);
  localparam logic [PH_W-1:0] PH_SAT     = PH_W'(PH_MAX);
  localparam logic [HD_W-1:0] HOLD_LIM   = HD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_INTRO      = 2'd0,
    ST_FIGHT      = 2'd1,
    ST_ROUND_OVER = 2'd2,
    ST_MATCH_OVER = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d, phase_inc;
  logic [HD_W-1:0]        hold_q, hold_d, hold_inc;
  logic [TL_W-1:0]        time_q, time_d;
  logic [NUM_PLAYERS-1:0] rw_q, rw_d, mw_q, mw_d;
  logic                   draw_q, draw_d, rr_q, rr_d;
  logic [NUM_PLAYERS-1:0] award, match_pt;
  logic                   clr_wins, hold_cond, restart;

  logic [NUM_PLAYERS-1:0][HP_W-1:0] hp;
  logic [NUM_PLAYERS-1:0][WW-1:0]   wins;

  logic [NUM_PLAYERS-1:0] alive, at_max, res_win;
  logic [HP_W-1:0]        max_hp;
  int                     alive_cnt, max_cnt;
  logic                   result, res_draw;

  assign hp        = health_flat;
  assign wins_flat = wins;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    mrc_win_lane #(.WIN_ROUNDS(WIN_ROUNDS), .WW(WW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr_wins),
      .award    (award[p]),
      .wins     (wins[p]),
      .match_pt (match_pt[p])
    );
  end

  // judge the current health snapshot: KO first, then time-out on the last tick
  always_comb begin
    alive     = '0;
    at_max    = '0;
    max_hp    = '0;
    alive_cnt = 0;
    max_cnt   = 0;
    result    = 1'b0;
    res_draw  = 1'b0;
    res_win   = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      alive[p] = (hp[p] != '0);
      if (alive[p]) alive_cnt = alive_cnt + 1;
      if (hp[p] > max_hp) max_hp = hp[p];
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      at_max[p] = (hp[p] == max_hp);
      if (at_max[p]) max_cnt = max_cnt + 1;
    end
    if (alive_cnt == 0) begin
      result   = 1'b1;
      res_draw = 1'b1;
    end else if (alive_cnt == 1) begin
      result  = 1'b1;
      res_win = alive;
    end else if (time_q == TL_ONE) begin
      result = 1'b1;
      if (max_cnt == 1) res_win  = at_max;
      else              res_draw = 1'b1;
    end
  end

  // next-state logic; a completed restart hold overrides any round transition
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    time_d    = time_q;
    rw_d      = rw_q;
    mw_d      = mw_q;
    draw_d    = draw_q;
    rr_d      = 1'b0;
    award     = '0;
    clr_wins  = 1'b0;
    phase_inc = (phase_q == PH_SAT) ? phase_q : phase_q + PH_W'(1);
    hold_inc  = (hold_q == HOLD_LIM) ? hold_q : hold_q + HD_W'(1);
    hold_cond = (restart_btn && state_q == ST_MATCH_OVER) || force_restart;
    restart   = tick && hold_cond && (hold_inc == HOLD_LIM);

    if (tick) hold_d = hold_cond ? hold_inc : '0;

    if (restart) begin
      state_d  = ST_INTRO;
      phase_d  = '0;
      hold_d   = '0;
      time_d   = TL_INIT;
      rw_d     = '0;
      mw_d     = '0;
      draw_d   = 1'b0;
      rr_d     = 1'b1;
      clr_wins = 1'b1;
    end else if (tick) begin
      case (state_q)
        ST_INTRO: begin
          phase_d = phase_inc;
          if (phase_inc == INTRO_LIM) begin
            state_d = ST_FIGHT;
            phase_d = '0;
            time_d  = TL_INIT;
          end
        end
        ST_FIGHT: begin
          if (result) begin
            time_d  = '0;
            phase_d = '0;
            rw_d    = res_win;
            draw_d  = res_draw;
            award   = res_win;
            if (|(res_win & match_pt)) begin
              state_d = ST_MATCH_OVER;
              mw_d    = res_win;
            end else begin
              state_d = ST_ROUND_OVER;
            end
          end else if (time_q != '0) begin
            time_d = time_q - TL_ONE;
          end
        end
        ST_ROUND_OVER: begin
          phase_d = phase_inc;
          if (phase_inc == RESULT_LIM) begin
            state_d = ST_INTRO;
            phase_d = '0;
            rr_d    = 1'b1;
            rw_d    = '0;
            draw_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INTRO;
      phase_q <= '0;
      hold_q  <= '0;
      time_q  <= TL_INIT;
      rw_q    <= '0;
      mw_q    <= '0;
      draw_q  <= 1'b0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      time_q  <= time_d;
      rw_q    <= rw_d;
      mw_q    <= mw_d;
      draw_q  <= draw_d;
      rr_q    <= rr_d;
    end
  end

  assign round_state   = state_q;
  assign round_reset   = rr_q;
  assign freeze_inputs = (state_q != ST_FIGHT);
  assign time_left     = time_q;
  assign round_winner  = rw_q;
  assign round_draw    = draw_q;
  assign match_winner  = mw_q;
endmodule

// File: tb/tb_match_round_controller.sv
// Bench for match_round_controller: directed scenarios on a 2-player and a
// 3-player instance, then a long random run checked against a tick-level model.
module tb_match_round_controller;
  localparam int HPW  = 9;
  localparam int WR   = 2;
  localparam int RT_A = 10;
  localparam int RT_B = 100;
  localparam int IT   = 3;
  localparam int RS   = 60;
  localparam int HT   = 40;

  logic clk = 1'b0;
  logic reset, tick;
  logic [2*HPW-1:0] health_a;
  logic [3*HPW-1:0] health_b;
  logic btn_a, frc_a, btn_b, frc_b;
  logic [1:0] st_a, st_b;
  logic       rr_a, fz_a, dr_a, rr_b, fz_b, dr_b;
  logic [3:0] tl_a;
  logic [6:0] tl_b;
  logic [1:0] rw_a, mw_a;
  logic [2:0] rw_b, mw_b;
  logic [3:0] wins_a;
  logic [5:0] wins_b;

  int n_chk = 0;
  int n_fail = 0;

  // stimulus state
  int h[2][4];
  bit btn[2], frc[2];

  // reference model state (per instance)
  int m_st[2], m_cnt[2], m_hold[2], m_tl[2], m_rw[2], m_mw[2];
  int m_wins[2][4];
  bit m_draw[2], m_rr[2];

  always #5 clk = ~clk;

  match_round_controller #(.NUM_PLAYERS(2), .HP_W(HPW), .WIN_ROUNDS(WR), .ROUND_TICKS(RT_A),
    .INTRO_TICKS(IT), .RESULT_TICKS(RS), .HOLD_TICKS(HT)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .health_flat(health_a), .restart_btn(btn_a),
    .force_restart(frc_a), .round_state(st_a), .round_reset(rr_a), .freeze_inputs(fz_a),
    .time_left(tl_a), .round_winner(rw_a), .round_draw(dr_a), .match_winner(mw_a),
    .wins_flat(wins_a));

  match_round_controller #(.NUM_PLAYERS(3), .HP_W(HPW), .WIN_ROUNDS(WR), .ROUND_TICKS(RT_B),
    .INTRO_TICKS(IT), .RESULT_TICKS(RS), .HOLD_TICKS(HT)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .health_flat(health_b), .restart_btn(btn_b),
    .force_restart(frc_b), .round_state(st_b), .round_reset(rr_b), .freeze_inputs(fz_b),
    .time_left(tl_b), .round_winner(rw_b), .round_draw(dr_b), .match_winner(mw_b),
    .wins_flat(wins_b));

  task automatic model_clear(input int k);
    m_st[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_tl[k] = (k == 0) ? RT_A : RT_B;
    m_rw[k] = 0; m_mw[k] = 0; m_draw[k] = 0; m_rr[k] = 1;
    for (int p = 0; p < 4; p++) m_wins[k][p] = 0;
  endtask

  // one clk of the match rules, in plain integer terms
  task automatic model_step(input int k);
    int np, alive, last, best, nbest, top, w;
    bit want, decided;
    np = (k == 0) ? 2 : 3;
    m_rr[k] = 0;
    if (reset) begin
      model_clear(k);
    end else if (tick) begin
      want = (btn[k] && m_st[k] == 3) || frc[k];
      m_hold[k] = want ? ((m_hold[k] < HT) ? m_hold[k] + 1 : HT) : 0;
      if (want && m_hold[k] == HT) begin
        model_clear(k);
      end else if (m_st[k] == 0) begin
        m_cnt[k]++;
        if (m_cnt[k] == IT) begin m_st[k] = 1; m_cnt[k] = 0; m_tl[k] = (k == 0) ? RT_A : RT_B; end
      end else if (m_st[k] == 1) begin
        alive = 0; last = -1; best = -1; nbest = 0; top = -1; w = -1; decided = 0;
        for (int p = 0; p < np; p++) begin
          if (h[k][p] != 0) begin alive++; last = p; end
          if (h[k][p] > best) best = h[k][p];
        end
        for (int p = 0; p < np; p++) if (h[k][p] == best) begin nbest++; top = p; end
        if (alive == 0) decided = 1;
        else if (alive == 1) begin decided = 1; w = last; end
        else if (m_tl[k] == 1) begin decided = 1; if (nbest == 1) w = top; end
        else m_tl[k]--;
        if (decided) begin
          m_tl[k] = 0;
          m_draw[k] = (w < 0);
          m_rw[k] = (w < 0) ? 0 : (1 << w);
          if (w >= 0 && m_wins[k][w] < WR) m_wins[k][w]++;
          if (w >= 0 && m_wins[k][w] == WR) begin m_st[k] = 3; m_mw[k] = m_rw[k]; end
          else begin m_st[k] = 2; m_cnt[k] = 0; end
        end
      end else if (m_st[k] == 2) begin
        m_cnt[k]++;
        if (m_cnt[k] == RS) begin m_st[k] = 0; m_cnt[k] = 0; m_rr[k] = 1; m_rw[k] = 0; m_draw[k] = 0; end
      end
    end
  endtask

  task automatic clk_cycle(input bit tk);
    tick = tk;
    btn_a = btn[0]; frc_a = frc[0]; btn_b = btn[1]; frc_b = frc[1];
    health_a = {9'(h[0][1]), 9'(h[0][0])};
    health_b = {9'(h[1][2]), 9'(h[1][1]), 9'(h[1][0])};
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_tick();
    clk_cycle(1'b1);
    clk_cycle(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_cycle(1'b1);
    clk_cycle(1'b1);
    n_chk++; if (st_a !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st_a); end
    n_chk++; if (rr_a !== 1'b1) begin n_fail++; $display("FAIL reset_round_reset got %0b want 1", rr_a); end
    n_chk++; if (fz_a !== 1'b1) begin n_fail++; $display("FAIL reset_freeze got %0b want 1", fz_a); end
    n_chk++; if (tl_a !== 4'd10) begin n_fail++; $display("FAIL reset_time_left got %0d want 10", tl_a); end
    n_chk++; if ({rw_a, dr_a, mw_a, wins_a} !== 9'd0) begin n_fail++; $display("FAIL reset_results got %h want 0", {rw_a, dr_a, mw_a, wins_a}); end
    reset = 1'b0;
    clk_cycle(1'b0);
    n_chk++; if (rr_a !== 1'b0) begin n_fail++; $display("FAIL reset_release_rr got %0b want 0", rr_a); end
  endtask

  task automatic test_intro();
    do_tick(); do_tick();
    n_chk++; if (st_a !== 2'd0) begin n_fail++; $display("FAIL intro_early got %0d want 0", st_a); end
    do_tick();
    n_chk++; if (st_a !== 2'd1) begin n_fail++; $display("FAIL intro_fight got %0d want 1", st_a); end
    n_chk++; if (tl_a !== 4'd10) begin n_fail++; $display("FAIL intro_time got %0d want 10", tl_a); end
    n_chk++; if (fz_a !== 1'b0) begin n_fail++; $display("FAIL intro_freeze got %0b want 0", fz_a); end
  endtask

  task automatic test_ko();
    do_tick();
    n_chk++; if (tl_a !== 4'd9) begin n_fail++; $display("FAIL ko_countdown got %0d want 9", tl_a); end
    h[0][0] = 50; h[0][1] = 0;
    do_tick();
    n_chk++; if (rw_a !== 2'b01) begin n_fail++; $display("FAIL ko_winner got %b want 01", rw_a); end
    n_chk++; if (wins_a !== 4'b0001) begin n_fail++; $display("FAIL ko_wins got %b want 0001", wins_a); end
    n_chk++; if (st_a !== 2'd2 || tl_a !== 4'd0) begin n_fail++; $display("FAIL ko_state got st=%0d tl=%0d want st=2 tl=0", st_a, tl_a); end
    h[0][0] = 100; h[0][1] = 100;
    for (int i = 0; i < RS - 1; i++) do_tick();
    n_chk++; if (st_a !== 2'd2) begin n_fail++; $display("FAIL ko_result_hold got %0d want 2", st_a); end
    clk_cycle(1'b1);
    n_chk++; if (rr_a !== 1'b1 || st_a !== 2'd0 || rw_a !== 2'b00) begin n_fail++; $display("FAIL ko_next_round got rr=%0b st=%0d rw=%b want 1 0 00", rr_a, st_a, rw_a); end
    clk_cycle(1'b0);
    n_chk++; if (rr_a !== 1'b0) begin n_fail++; $display("FAIL ko_pulse_width got %0b want 0", rr_a); end
  endtask

  task automatic test_double_ko();
    for (int i = 0; i < IT; i++) do_tick();
    h[0][0] = 0; h[0][1] = 0;
    do_tick();
    n_chk++; if (dr_a !== 1'b1 || rw_a !== 2'b00) begin n_fail++; $display("FAIL dko_draw got dr=%0b rw=%b want 1 00", dr_a, rw_a); end
    n_chk++; if (wins_a !== 4'b0001 || st_a !== 2'd2) begin n_fail++; $display("FAIL dko_wins got w=%b st=%0d want 0001 2", wins_a, st_a); end
    h[0][0] = 100; h[0][1] = 100;
    for (int i = 0; i < RS; i++) do_tick();
    n_chk++; if (st_a !== 2'd0 || dr_a !== 1'b0) begin n_fail++; $display("FAIL dko_next got st=%0d dr=%0b want 0 0", st_a, dr_a); end
  endtask

  task automatic test_timeout();
    h[0][0] = 80; h[0][1] = 80;
    for (int i = 0; i < IT; i++) do_tick();
    for (int i = 0; i < RT_A - 1; i++) do_tick();
    n_chk++; if (st_a !== 2'd1 || tl_a !== 4'd1) begin n_fail++; $display("FAIL to_last_tick got st=%0d tl=%0d want 1 1", st_a, tl_a); end
    do_tick();
    n_chk++; if (dr_a !== 1'b1 || st_a !== 2'd2 || tl_a !== 4'd0) begin n_fail++; $display("FAIL to_draw got dr=%0b st=%0d tl=%0d want 1 2 0", dr_a, st_a, tl_a); end
    n_chk++; if (wins_a !== 4'b0001) begin n_fail++; $display("FAIL to_draw_wins got %b want 0001", wins_a); end
    for (int i = 0; i < RS; i++) do_tick();
  endtask

  task automatic test_match();
    h[0][0] = 80; h[0][1] = 79;
    for (int i = 0; i < IT + RT_A; i++) do_tick();
    n_chk++; if (rw_a !== 2'b01 || mw_a !== 2'b01) begin n_fail++; $display("FAIL match_winner got rw=%b mw=%b want 01 01", rw_a, mw_a); end
    n_chk++; if (st_a !== 2'd3 || wins_a !== 4'b0010) begin n_fail++; $display("FAIL match_state got st=%0d w=%b want 3 0010", st_a, wins_a); end
  endtask

  task automatic test_restart_hold();
    btn[0] = 1;
    for (int i = 0; i < HT - 1; i++) do_tick();
    btn[0] = 0;
    do_tick();
    n_chk++; if (st_a !== 2'd3 || mw_a !== 2'b01) begin n_fail++; $display("FAIL hold39 got st=%0d mw=%b want 3 01", st_a, mw_a); end
    btn[0] = 1;
    for (int i = 0; i < HT - 1; i++) do_tick();
    n_chk++; if (st_a !== 2'd3) begin n_fail++; $display("FAIL hold_early got %0d want 3", st_a); end
    clk_cycle(1'b1);
    n_chk++; if (st_a !== 2'd0 || rr_a !== 1'b1) begin n_fail++; $display("FAIL hold40 got st=%0d rr=%0b want 0 1", st_a, rr_a); end
    n_chk++; if ({wins_a, mw_a, rw_a} !== 8'd0) begin n_fail++; $display("FAIL hold40_clear got %h want 0", {wins_a, mw_a, rw_a}); end
    btn[0] = 0;
    clk_cycle(1'b0);
    n_chk++; if (rr_a !== 1'b0) begin n_fail++; $display("FAIL hold_pulse got %0b want 0", rr_a); end
  endtask

  task automatic test_three_player();
    h[1][0] = 100; h[1][1] = 100; h[1][2] = 100;
    reset = 1'b1;
    clk_cycle(1'b1);
    n_chk++; if (st_b !== 2'd0 || rr_b !== 1'b1 || tl_b !== 7'd100 || wins_b !== 6'd0) begin n_fail++; $display("FAIL p3_reset got st=%0d rr=%0b tl=%0d w=%b", st_b, rr_b, tl_b, wins_b); end
    reset = 1'b0;
    clk_cycle(1'b0);
    for (int i = 0; i < IT; i++) do_tick();
    h[1][0] = 0; h[1][1] = 70; h[1][2] = 0;
    do_tick();
    n_chk++; if (rw_b !== 3'b010 || wins_b !== 6'b000100 || st_b !== 2'd2) begin n_fail++; $display("FAIL p3_ko got rw=%b w=%b st=%0d want 010 000100 2", rw_b, wins_b, st_b); end
    h[1][0] = 90; h[1][1] = 50; h[1][2] = 60;
    for (int i = 0; i < RS + IT; i++) do_tick();
    n_chk++; if (st_b !== 2'd1) begin n_fail++; $display("FAIL p3_fight2 got %0d want 1", st_b); end
    frc[1] = 1;
    for (int i = 0; i < HT - 1; i++) do_tick();
    n_chk++; if (st_b !== 2'd1 || tl_b !== 7'd61) begin n_fail++; $display("FAIL p3_force_early got st=%0d tl=%0d want 1 61", st_b, tl_b); end
    h[1][0] = 0; h[1][2] = 0;
    clk_cycle(1'b1);
    n_chk++; if (st_b !== 2'd0 || rr_b !== 1'b1 || wins_b !== 6'd0 || rw_b !== 3'd0) begin n_fail++; $display("FAIL p3_force got st=%0d rr=%0b w=%b rw=%b want 0 1 0 0", st_b, rr_b, wins_b, rw_b); end
    frc[1] = 0;
    h[1][0] = 100; h[1][2] = 100;
    clk_cycle(1'b0);
  endtask

  task automatic test_random();
    logic [3:0] ew_a;
    logic [5:0] ew_b;
    int np, v;
    for (int c = 0; c < 6000 && n_fail < 40; c++) begin
      reset = ($urandom_range(0, 1999) == 0);
      for (int k = 0; k < 2; k++) begin
        np = (k == 0) ? 2 : 3;
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 6))
            0: v = 0;   1: v = 1;   2: v = 79;  3: v = 80;
            4: v = 80;  5: v = 200; default: v = 511;
          endcase
          h[k][$urandom_range(0, np - 1)] = v;
        end
        if ($urandom_range(0, 149) == 0) btn[k] = ~btn[k];
        if ($urandom_range(0, 399) == 0) frc[k] = ~frc[k];
      end
      clk_cycle($urandom_range(0, 2) == 0);
      for (int p = 0; p < 2; p++) ew_a[p*2 +: 2] = 2'(m_wins[0][p]);
      for (int p = 0; p < 3; p++) ew_b[p*2 +: 2] = 2'(m_wins[1][p]);
      n_chk++; if (st_a !== 2'(m_st[0])) begin n_fail++; $display("FAIL rnd_a_state cyc %0d got %0d want %0d", c, st_a, m_st[0]); end
      n_chk++; if (rr_a !== m_rr[0]) begin n_fail++; $display("FAIL rnd_a_rr cyc %0d got %0b want %0b", c, rr_a, m_rr[0]); end
      n_chk++; if (fz_a !== (m_st[0] != 1)) begin n_fail++; $display("FAIL rnd_a_freeze cyc %0d got %0b want %0b", c, fz_a, m_st[0] != 1); end
      if (m_st[0] != 0) begin
        n_chk++; if (tl_a !== 4'(m_tl[0])) begin n_fail++; $display("FAIL rnd_a_time cyc %0d got %0d want %0d", c, tl_a, m_tl[0]); end
      end
      n_chk++; if (rw_a !== 2'(m_rw[0]) || dr_a !== m_draw[0]) begin n_fail++; $display("FAIL rnd_a_round cyc %0d got rw=%b dr=%0b want %0d %0b", c, rw_a, dr_a, m_rw[0], m_draw[0]); end
      n_chk++; if (mw_a !== 2'(m_mw[0]) || wins_a !== ew_a) begin n_fail++; $display("FAIL rnd_a_match cyc %0d got mw=%b w=%b want %0d %b", c, mw_a, wins_a, m_mw[0], ew_a); end
      n_chk++; if (st_b !== 2'(m_st[1]) || rr_b !== m_rr[1] || fz_b !== (m_st[1] != 1)) begin n_fail++; $display("FAIL rnd_b_state cyc %0d got st=%0d rr=%0b want %0d %0b", c, st_b, rr_b, m_st[1], m_rr[1]); end
      if (m_st[1] != 0) begin
        n_chk++; if (tl_b !== 7'(m_tl[1])) begin n_fail++; $display("FAIL rnd_b_time cyc %0d got %0d want %0d", c, tl_b, m_tl[1]); end
      end
      n_chk++; if (rw_b !== 3'(m_rw[1]) || dr_b !== m_draw[1]) begin n_fail++; $display("FAIL rnd_b_round cyc %0d got rw=%b dr=%0b want %0d %0b", c, rw_b, dr_b, m_rw[1], m_draw[1]); end
      n_chk++; if (mw_b !== 3'(m_mw[1]) || wins_b !== ew_b) begin n_fail++; $display("FAIL rnd_b_match cyc %0d got mw=%b w=%b want %0d %b", c, mw_b, wins_b, m_mw[1], ew_b); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    btn = '{0, 0}; frc = '{0, 0};
    for (int k = 0; k < 2; k++) for (int p = 0; p < 4; p++) h[k][p] = 100;
    model_clear(0); model_clear(1);
    test_reset();
    test_intro();
    test_ko();
    test_double_ko();
    test_timeout();
    test_match();
    test_restart_hold();
    test_three_player();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
